// File: rtl/udma_tgen_pkg.sv
// Shared types and LFSR tap table for the uDMA RX traffic generator.
package udma_tgen_pkg;

  typedef enum logic [1:0] {
    TGEN_INCR  = 2'd0,
    TGEN_CONST = 2'd1,
    TGEN_LFSR  = 2'd2,
    TGEN_RSVD  = 2'd3
  } tgen_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } tgen_state_e;

  // Galois (right-shift) tap masks for maximal-length sequences.
  function automatic logic [63:0] lfsr_taps(input int unsigned width);
    logic [63:0] taps;
    case (width)
      4:       taps = 64'h0000_0000_0000_0009;
      8:       taps = 64'h0000_0000_0000_00B8;
      16:      taps = 64'h0000_0000_0000_B400;
      24:      taps = 64'h0000_0000_00E1_0000;
      32:      taps = 64'h0000_0000_8020_0003;
      64:      taps = 64'hD800_0000_0000_0000;
      default: taps = (64'd1 << (width - 1)) | 64'd1;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/udma_tgen_lfsr.sv
// Galois LFSR pattern source: load at burst start, one step per enable.
// Only instantiated when UDMA_TGEN_LFSR_EN is defined.
module udma_tgen_lfsr
  import udma_tgen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_val_i,
  input  logic                  en_i,
  output logic [DATA_WIDTH-1:0] state_o
);

  localparam logic [63:0]           TapsFull = lfsr_taps(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] Taps     = TapsFull[DATA_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = load_val_i;
    end else if (en_i) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? Taps : '0);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/udma_traffic_gen_stream.sv
// uDMA RX-side traffic generator: bursts of patterned words on a valid/ready stream.
// Define UDMA_TGEN_LFSR_EN to enable the LFSR pattern (mode 2); otherwise mode 2 acts as CONST.
module udma_traffic_gen_stream
  import udma_tgen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned GAP_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cfg_start_i,
  input  logic                  cfg_stop_i,
  input  logic [1:0]            cfg_mode_i,
  input  logic [DATA_WIDTH-1:0] cfg_seed_i,
  input  logic [DATA_WIDTH-1:0] cfg_step_i,
  input  logic [CNT_WIDTH-1:0]  cfg_len_i,
  input  logic [GAP_WIDTH-1:0]  cfg_gap_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  words_sent_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i
);

  tgen_state_e           state_q, state_d;
  tgen_mode_e            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  words_q, words_d;
  logic [GAP_WIDTH-1:0]  gap_q, gap_d;
  logic [GAP_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  stop_pend_q, stop_pend_d;
  logic                  done_q, done_d;

  logic                  start_go;
  logic                  handshake;
  logic [DATA_WIDTH-1:0] seed_eff;
  logic [DATA_WIDTH-1:0] data_next;

  // Stop beats start when both arrive in IDLE.
  assign start_go  = (state_q == IDLE) && cfg_start_i && !cfg_stop_i && (cfg_len_i != '0);
  assign handshake = (state_q == EMIT) && rx_ready_i;

`ifdef UDMA_TGEN_LFSR_EN
  logic [DATA_WIDTH-1:0] lfsr_state;

  // An all-zero seed would lock the LFSR up.
  assign seed_eff = ((tgen_mode_e'(cfg_mode_i) == TGEN_LFSR) && (cfg_seed_i == '0)) ?
                    DATA_WIDTH'(1) : cfg_seed_i;

  udma_tgen_lfsr #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lfsr (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .load_i     (start_go && (tgen_mode_e'(cfg_mode_i) == TGEN_LFSR)),
    .load_val_i (seed_eff),
    .en_i       (handshake && (mode_q == TGEN_LFSR)),
    .state_o    (lfsr_state)
  );

  assign rx_data_o = (mode_q == TGEN_LFSR) ? lfsr_state : data_q;
`else
  assign seed_eff  = cfg_seed_i;
  assign rx_data_o = data_q;
`endif

  always_comb begin
    data_next = data_q;
    if (mode_q == TGEN_INCR) begin
      data_next = data_q + step_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    step_d      = step_q;
    data_d      = data_q;
    len_d       = len_q;
    words_d     = words_q;
    gap_d       = gap_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_go) begin
          mode_d      = tgen_mode_e'(cfg_mode_i);
          step_d      = cfg_step_i;
          len_d       = cfg_len_i;
          gap_d       = cfg_gap_i;
          data_d      = seed_eff;
          words_d     = '0;
          stop_pend_d = 1'b0;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (cfg_stop_i) begin
          stop_pend_d = 1'b1;
        end
        if (rx_ready_i) begin
          words_d = words_q + 1'b1;
          data_d  = data_next;
          // Completion takes priority over a concurrent or pending stop.
          if (words_d == len_q) begin
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
            state_d     = IDLE;
          end else if (stop_pend_q || cfg_stop_i) begin
            stop_pend_d = 1'b0;
            state_d     = IDLE;
          end else if (gap_q != '0) begin
            cnt_d   = gap_q;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        cnt_d = cnt_q - 1'b1;
        if (cfg_stop_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == GAP_WIDTH'(1)) begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      mode_q      <= TGEN_INCR;
      step_q      <= '0;
      data_q      <= '0;
      len_q       <= '0;
      words_q     <= '0;
      gap_q       <= '0;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      step_q      <= step_d;
      data_q      <= data_d;
      len_q       <= len_d;
      words_q     <= words_d;
      gap_q       <= gap_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign rx_valid_o   = (state_q == EMIT);
  assign done_o       = done_q;
  assign words_sent_o = words_q;

endmodule

// File: tb/tb_udma_traffic_gen_stream.sv
// Directed self-checking bench for udma_traffic_gen_stream.
module tb_udma_traffic_gen_stream;

  logic        clk;
  logic        rstn;
  logic        cfg_start;
  logic        cfg_stop;
  logic [1:0]  cfg_mode;
  logic [31:0] cfg_seed;
  logic [31:0] cfg_step;
  logic [15:0] cfg_len;
  logic [7:0]  cfg_gap;
  logic        busy;
  logic        done;
  logic [15:0] words_sent;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int n_checks = 0;
  int n_errors = 0;

  udma_traffic_gen_stream #(
    .DATA_WIDTH (32),
    .CNT_WIDTH  (16),
    .GAP_WIDTH  (8)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .cfg_start_i  (cfg_start),
    .cfg_stop_i   (cfg_stop),
    .cfg_mode_i   (cfg_mode),
    .cfg_seed_i   (cfg_seed),
    .cfg_step_i   (cfg_step),
    .cfg_len_i    (cfg_len),
    .cfg_gap_i    (cfg_gap),
    .busy_o       (busy),
    .done_o       (done),
    .words_sent_o (words_sent),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .rx_ready_i   (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] mode, input logic [31:0] seed, input logic [31:0] step,
                         input logic [15:0] len, input logic [7:0] gap);
    cfg_mode = mode;
    cfg_seed = seed;
    cfg_step = step;
    cfg_len  = len;
    cfg_gap  = gap;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  initial begin
    rstn      = 1'b0;
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    rx_ready  = 1'b1;
    set_cfg(2'd0, 32'h0, 32'h0, 16'd0, 8'd0);
    #3;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(rx_valid), 64'd0);
    check("rst_data", 64'(rx_data), 64'd0);
    check("rst_words", 64'(words_sent), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rstn = 1'b1;
    tick();

    // INCR back-to-back
    set_cfg(2'd0, 32'h10, 32'h4, 16'd4, 8'd0);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      check("incr_valid", 64'(rx_valid), 64'd1);
      check("incr_data", 64'(rx_data), 64'(32'h10 + 32'(4 * i)));
      check("incr_done_low", 64'(done), 64'd0);
      tick();
    end
    check("incr_done", 64'(done), 64'd1);
    check("incr_words", 64'(words_sent), 64'd4);
    check("incr_idle", 64'(busy), 64'd0);
    tick();
    check("incr_done_pulse", 64'(done), 64'd0);

    // Gap of 3 idle cycles
    set_cfg(2'd0, 32'h0, 32'h1, 16'd3, 8'd3);
    pulse_start();
    for (int w = 0; w < 3; w++) begin
      check("gap_valid", 64'(rx_valid), 64'd1);
      check("gap_data", 64'(rx_data), 64'(w));
      tick();
      if (w != 2) begin
        for (int g = 0; g < 3; g++) begin
          check("gap_idle_valid", 64'(rx_valid), 64'd0);
          check("gap_busy", 64'(busy), 64'd1);
          tick();
        end
      end
    end
    check("gap_done", 64'(done), 64'd1);
    tick();

    // Backpressure on word 2
    set_cfg(2'd0, 32'h100, 32'h10, 16'd4, 8'd0);
    pulse_start();
    check("bp_w0", 64'(rx_data), 64'h100);
    tick();
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 64'(rx_valid), 64'd1);
      check("bp_hold_data", 64'(rx_data), 64'h110);
      tick();
    end
    check("bp_hold_words", 64'(words_sent), 64'd1);
    rx_ready = 1'b1;
    tick();
    check("bp_w2", 64'(rx_data), 64'h120);
    tick();
    check("bp_w3", 64'(rx_data), 64'h130);
    tick();
    check("bp_done", 64'(done), 64'd1);
    check("bp_words", 64'(words_sent), 64'd4);
    tick();

    // Stop during EMIT while stalled
    set_cfg(2'd0, 32'h0, 32'h1, 16'd5, 8'd0);
    rx_ready = 1'b0;
    pulse_start();
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    check("stop_hold_valid", 64'(rx_valid), 64'd1);
    tick();
    check("stop_hold_data", 64'(rx_data), 64'd0);
    rx_ready = 1'b1;
    tick();
    check("stop_idle", 64'(busy), 64'd0);
    check("stop_valid", 64'(rx_valid), 64'd0);
    check("stop_no_done", 64'(done), 64'd0);
    check("stop_words", 64'(words_sent), 64'd1);
    tick();
    check("stop_no_done2", 64'(done), 64'd0);
    check("stop_words_hold", 64'(words_sent), 64'd1);

    // Stop during GAP
    set_cfg(2'd0, 32'h0, 32'h1, 16'd4, 8'd5);
    pulse_start();
    tick();
    check("gstop_in_gap", 64'(rx_valid), 64'd0);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    check("gstop_idle", 64'(busy), 64'd0);
    check("gstop_no_done", 64'(done), 64'd0);
    check("gstop_words", 64'(words_sent), 64'd1);

    // Wrap-around
    set_cfg(2'd0, 32'hFFFF_FFFE, 32'h1, 16'd3, 8'd0);
    pulse_start();
    check("wrap_0", 64'(rx_data), 64'hFFFF_FFFE);
    tick();
    check("wrap_1", 64'(rx_data), 64'hFFFF_FFFF);
    tick();
    check("wrap_2", 64'(rx_data), 64'h0);
    tick();
    check("wrap_done", 64'(done), 64'd1);
    tick();

    // CONST and reserved mode
    set_cfg(2'd1, 32'hABCD, 32'h5, 16'd2, 8'd0);
    pulse_start();
    check("const_0", 64'(rx_data), 64'hABCD);
    tick();
    check("const_1", 64'(rx_data), 64'hABCD);
    tick();
    set_cfg(2'd3, 32'h1234, 32'h5, 16'd2, 8'd0);
    pulse_start();
    tick();
    check("rsvd_1", 64'(rx_data), 64'h1234);
    tick();

    // Mode 2
    set_cfg(2'd2, 32'h0, 32'h5, 16'd2, 8'd0);
    pulse_start();
`ifdef UDMA_TGEN_LFSR_EN
    check("lfsr_0", 64'(rx_data), 64'h1);
    tick();
    check("lfsr_1", 64'(rx_data), 64'h8020_0003);
`else
    check("mode2_0", 64'(rx_data), 64'h0);
    tick();
    check("mode2_1", 64'(rx_data), 64'h0);
`endif
    tick();
    check("mode2_done", 64'(done), 64'd1);
    tick();

    // len=0 start ignored
    set_cfg(2'd0, 32'h5, 32'h1, 16'd0, 8'd0);
    pulse_start();
    check("len0_busy", 64'(busy), 64'd0);
    check("len0_valid", 64'(rx_valid), 64'd0);

    // start+stop together in IDLE
    set_cfg(2'd0, 32'h5, 32'h1, 16'd2, 8'd0);
    cfg_stop = 1'b1;
    pulse_start();
    cfg_stop = 1'b0;
    check("startstop_busy", 64'(busy), 64'd0);

    // start during burst ignored
    set_cfg(2'd0, 32'h50, 32'h1, 16'd3, 8'd0);
    pulse_start();
    check("rebusy_0", 64'(rx_data), 64'h50);
    cfg_start = 1'b1;
    set_cfg(2'd0, 32'h999, 32'h7, 16'd7, 8'd0);
    tick();
    cfg_start = 1'b0;
    check("rebusy_1", 64'(rx_data), 64'h51);
    tick();
    check("rebusy_2", 64'(rx_data), 64'h52);
    tick();
    check("rebusy_done", 64'(done), 64'd1);
    check("rebusy_words", 64'(words_sent), 64'd3);
    tick();

    // Reset mid-burst
    set_cfg(2'd0, 32'h77, 32'h1, 16'd10, 8'd0);
    pulse_start();
    tick();
    #2;
    rstn = 1'b0;
    #1;
    check("mrst_valid", 64'(rx_valid), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_data", 64'(rx_data), 64'd0);
    check("mrst_words", 64'(words_sent), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    #2;
    rstn = 1'b1;
    tick();
    check("mrst_stay_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
